// File: rtl/io_spi_seq.sv
// Transfer sequencer that drives the SPI lite controller register port from 16-byte TX/RX buffers.
// CPU register reads return one cycle after the strobe; the SPI port is only driven while seq_busy is high.
module io_spi_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_io_we,
  input  logic [15:2] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [15:2] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  output logic        m_io_we,
  output logic [15:2] m_io_wadr,
  output logic [31:0] m_io_wdata,
  output logic [15:2] m_io_radr,
  output logic        m_io_radr_en,
  input  logic [31:0] m_io_rdata,
  output logic        seq_busy,
  output logic        seq_done
);

  localparam logic [15:2] A_MOSI = 14'h3C82;
  localparam logic [15:2] A_MISO = 14'h3C83;
  localparam logic [15:2] A_CTRL = 14'h3C84;
  localparam logic [15:2] A_LEN  = 14'h3C85;
  localparam logic [15:2] A_TXD  = 14'h3C86;
  localparam logic [15:2] A_RXD  = 14'h3C87;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_TXST, S_TXCHK, S_TXWR, S_RXRD, S_RXCHK, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  tx_buf [16];
  logic [7:0]  rx_buf [16];
  logic [3:0]  wptr;
  logic [4:0]  len, tx_idx, rx_count, rptr;
  logic [7:0]  stall;
  logic        done, err;
  logic        rd_hit;
  logic [31:0] rd_dat, rd_val;

  logic busy, wr_ctrl, wr_len, wr_txd, rd_rxd;
  logic start_ok, abort_req, rx_valid, rx_empty, tx_left;
  logic [4:0] rx_count_upd;
  logic [7:0] stall_upd;

  assign busy      = (state != S_IDLE);
  assign wr_ctrl   = dma_io_we && (dma_io_wadr == A_CTRL);
  assign wr_len    = dma_io_we && (dma_io_wadr == A_LEN);
  assign wr_txd    = dma_io_we && (dma_io_wadr == A_TXD);
  assign rd_rxd    = dma_io_radr_en && (dma_io_radr == A_RXD);
  assign abort_req = wr_ctrl && dma_io_wdata[1];
  assign start_ok  = wr_ctrl && dma_io_wdata[0] && !dma_io_wdata[1] && !busy && (len != 5'd0);
  assign rx_valid  = (rptr < rx_count);
  assign rx_empty  = m_io_rdata[9];
  assign tx_left   = (tx_idx < len);

  // Empty polls only count as a stall once every TX byte has been pushed.
  assign rx_count_upd = rx_empty ? rx_count : rx_count + 5'd1;
  assign stall_upd    = !rx_empty ? 8'd0 : (tx_left ? stall : stall + 8'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_CLR;
      S_CLR:   state_nxt = S_TXST;
      S_TXST:  state_nxt = S_TXCHK;
      S_TXCHK: state_nxt = m_io_rdata[8] ? S_TXST : S_TXWR;
      S_TXWR:  state_nxt = S_RXRD;
      S_RXRD:  state_nxt = S_RXCHK;
      S_RXCHK: begin
        if (rx_count_upd == len)     state_nxt = S_DONE;
        else if (stall_upd == 8'hFF) state_nxt = S_DONE;
        else if (tx_left)            state_nxt = S_TXST;
        else                         state_nxt = S_RXRD;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_req && busy) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    m_io_we      = 1'b0;
    m_io_wadr    = '0;
    m_io_wdata   = '0;
    m_io_radr    = '0;
    m_io_radr_en = 1'b0;
    case (state)
      S_CLR:  begin m_io_we = 1'b1; m_io_wadr = A_MISO; m_io_wdata = 32'h400; end
      S_TXST: begin m_io_radr_en = 1'b1; m_io_radr = A_MOSI; end
      S_TXWR: begin m_io_we = 1'b1; m_io_wadr = A_MOSI; m_io_wdata = {24'd0, tx_buf[tx_idx[3:0]]}; end
      S_RXRD: begin m_io_radr_en = 1'b1; m_io_radr = A_MISO; end
      default: ;
    endcase
  end

  assign seq_busy = busy;
  assign seq_done = (state == S_DONE);

  always_comb begin
    rd_val = '0;
    case (dma_io_radr)
      A_CTRL:  rd_val = {19'd0, rx_count, 5'd0, err, done, busy};
      A_LEN:   rd_val = {27'd0, len};
      A_TXD:   rd_val = {28'd0, wptr};
      A_RXD:   rd_val = {23'd0, rx_valid, rx_buf[rptr[3:0]]};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        tx_buf[i] <= '0;
        rx_buf[i] <= '0;
      end
      wptr     <= '0;
      len      <= '0;
      tx_idx   <= '0;
      rx_count <= '0;
      rptr     <= '0;
      stall    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_hit   <= 1'b0;
      rd_dat   <= '0;
    end else begin
      if (wr_len) len <= (dma_io_wdata[4:0] > 5'd16) ? 5'd16 : dma_io_wdata[4:0];
      if (wr_txd && !busy) begin
        if (dma_io_wdata[8]) wptr <= '0;
        else begin
          tx_buf[wptr] <= dma_io_wdata[7:0];
          wptr         <= wptr + 4'd1;
        end
      end
      if (rd_rxd && rx_valid) rptr <= rptr + 5'd1;
      if (state == S_TXWR) tx_idx <= tx_idx + 5'd1;
      if (state == S_RXCHK) begin
        if (!rx_empty && !rx_count[4]) rx_buf[rx_count[3:0]] <= m_io_rdata[7:0];
        rx_count <= rx_count_upd;
        stall    <= stall_upd;
        if ((rx_count_upd != len) && (stall_upd == 8'hFF)) err <= 1'b1;
      end
      if (state == S_DONE) done <= 1'b1;
      // Start acceptance overrides the read-side rptr bump in the same cycle.
      if (start_ok) begin
        done     <= 1'b0;
        err      <= 1'b0;
        rx_count <= '0;
        rptr     <= '0;
        tx_idx   <= '0;
        stall    <= '0;
      end
      rd_hit <= dma_io_radr_en && (dma_io_radr >= A_CTRL) && (dma_io_radr <= A_RXD);
      rd_dat <= rd_val;
    end
  end

  assign dma_io_rdata = rd_hit ? rd_dat : dma_io_rdata_in;

  logic unused_bits;
  assign unused_bits = ^{dma_io_wdata[31:9], m_io_rdata[31:10]};

endmodule
